axil_regif_core: RTL and testbench
==================================

Name: axil_regif_core

Overview:
Parametrised AXI4-Lite slave register bank that fronts a generic iterative datapath core, such as a DES engine. It replaces the fixed four-register slave interface with a configurable register count and data width. It adds a control/status register pair, a start/done handshake to the core, result capture and a level interrupt. It sits between the AXI4-Lite interconnect and the core inside the IP wrapper.

Parameters:
DATA_W, 32, AXI data width; 32 or 64.
NUM_REGS, 8, number of registers; even, at least 4.
ADDR_W, 6, AXI address width; must satisfy 2^ADDR_W >= NUM_REGS*(DATA_W/8).
IN_REGS, (NUM_REGS-2)/2, derived: count of core input registers.
OUT_REGS, NUM_REGS-2-IN_REGS, derived: count of result registers.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_W  write data
S_AXI_WSTRB  in  DATA_W/8  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DATA_W  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
core_start  out  1  one-cycle start pulse to core
core_din  out  IN_REGS*DATA_W  concatenated input registers; reg 2 in the LSBs
core_dout  in  OUT_REGS*DATA_W  core result
core_done  in  1  one-cycle completion pulse from core
irq  out  1  level interrupt

Behaviour:
- Register map: index = addr[ADDR_W-1:log2(DATA_W/8)]; low address bits are ignored.
- Reg 0 CTRL (R/W):
  - bit0 START is write-only and always reads 0.
  - bit1 IRQ_EN is R/W.
  - Other bits read 0.
- Reg 1 STATUS (RO):
  - bit0 BUSY.
  - bit1 DONE is sticky; writing 1 to bit1 clears it (W1C).
- Regs 2..IN_REGS+1: R/W input registers, honour WSTRB per byte.
- Remaining regs: RO result registers; writes are ignored with OKAY response.
- Index >= NUM_REGS: writes have no effect, reads return 0, response SLVERR (2'b10). All other responses are OKAY (2'b00).
- Reset (async, immediate): every register, BUSY, DONE, IRQ_EN, AWREADY, WREADY, BVALID, ARREADY, RVALID, core_start and irq are 0. BRESP, RRESP and RDATA are 0.
- Write channel:
  - When AWVALID&WVALID&!BVALID&!AWREADY: AWREADY and WREADY pulse high together for 1 cycle and the register updates on that edge.
  - BVALID rises the next cycle and holds until BREADY.
  - A lone AWVALID or lone WVALID waits; there is no partial acceptance.
- Read channel:
  - When ARVALID&!RVALID&!ARREADY: ARREADY pulses for 1 cycle.
  - RVALID and RDATA are registered the next cycle; RDATA is held stable until RREADY.
- Write and read transactions in the same cycle are independent. A read returns the register value before the concurrent write edge.
- Start:
  - A write with WSTRB[0]=1 and WDATA[0]=1 to CTRL while BUSY=0 pulses core_start the cycle after acceptance and sets BUSY.
  - DONE clears on start.
  - Start while BUSY=1 is ignored; IRQ_EN is still updated.
- core_done:
  - Captures core_dout into the result registers.
  - Clears BUSY, sets DONE.
  - core_done while BUSY=0 is ignored.
- Simultaneous DONE W1C and core_done: set wins.
- irq = DONE & IRQ_EN, registered; asserts 1 cycle after DONE or IRQ_EN becomes true.
- core_din is driven continuously from the input registers. Software must not modify it while BUSY; the hardware does not block such writes.

Test Plan:
Defaults (DATA_W=32, NUM_REGS=8, ADDR_W=6):
- Reset, then write 0x00000001..0x00000003 to 0x08, 0x0C, 0x10 and read back -> each read matches, BRESP=RRESP=00, core_din=0x00000003_00000002_00000001.
- Write 0xAABBCCDD to 0x08 with WSTRB=4'b0101 over prior 0x11223344 -> read 0x11BB33DD.
- Write CTRL=0x3 -> core_start high exactly 1 cycle, STATUS=0x1; core_done with core_dout=0x0C_0B_0A -> regs 5/6/7 read 0x0A/0x0B/0x0C, STATUS=0x2, irq=1 next cycle; write STATUS=0x2 -> irq=0.
- Second CTRL start while BUSY -> no core_start pulse; core_done arriving the same cycle as a DONE W1C -> DONE stays 1.
- Read 0x20 and write 0x3C -> RRESP=BRESP=10, RDATA=0, no register changes. Write 0xFFFFFFFF to 0x14 -> OKAY, value unchanged.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and RDATA stable, no new AWREADY. Assert ARESET mid-transaction -> all outputs 0 immediately.

Source files
------------

// File: rtl/axil_regif_core_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and axil_regif_core (slave).
interface axil_regif_core_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axil_regif_core.sv
// AXI4-Lite register bank fronting an iterative core: CTRL/STATUS, input and
// result registers, start/done handshake and a level interrupt.
module axil_regif_core #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 6,
    parameter int IN_REGS  = (NUM_REGS - 2) / 2,
    parameter int OUT_REGS = NUM_REGS - 2 - IN_REGS
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    axil_regif_core_if.slave             s_axi,
    output logic                         core_start,
    output logic [IN_REGS*DATA_W-1:0]    core_din,
    input  logic [OUT_REGS*DATA_W-1:0]   core_dout,
    input  logic                         core_done,
    output logic                         irq
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int LSB      = $clog2(STRB_W);
    localparam int IN_BASE  = 2;
    localparam int OUT_BASE = 2 + IN_REGS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0] in_regs  [IN_REGS];
    logic [DATA_W-1:0] out_regs [OUT_REGS];
    logic              busy, done, irq_en;

    logic              aw_ready_q, b_valid_q;
    logic [1:0]        b_resp_q;
    logic              ar_ready_q, r_valid_q;
    logic [1:0]        r_resp_q;
    logic [DATA_W-1:0] r_data_q;

    logic [31:0]       w_idx, r_idx;
    logic              wr_fire, rd_fire, wr_err, rd_err;
    logic              wr_ctrl, start_req, clear_done;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_addr_lsbs;

    // Byte-offset bits select nothing; only the word index matters.
    assign w_idx            = 32'(s_axi.S_AXI_AWADDR[ADDR_W-1:LSB]);
    assign r_idx            = 32'(s_axi.S_AXI_ARADDR[ADDR_W-1:LSB]);
    assign unused_addr_lsbs = ^{s_axi.S_AXI_AWADDR[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0]};

    assign wr_fire    = aw_ready_q && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    assign rd_fire    = ar_ready_q && s_axi.S_AXI_ARVALID;
    assign wr_err     = w_idx >= 32'(NUM_REGS);
    assign rd_err     = r_idx >= 32'(NUM_REGS);
    assign wr_ctrl    = wr_fire && (w_idx == 32'd0) && s_axi.S_AXI_WSTRB[0];
    assign start_req  = wr_ctrl && s_axi.S_AXI_WDATA[0] && !busy;
    assign clear_done = wr_fire && (w_idx == 32'd1) && s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[1];

    assign s_axi.S_AXI_AWREADY = aw_ready_q;
    assign s_axi.S_AXI_WREADY  = aw_ready_q;
    assign s_axi.S_AXI_BVALID  = b_valid_q;
    assign s_axi.S_AXI_BRESP   = b_resp_q;
    assign s_axi.S_AXI_ARREADY = ar_ready_q;
    assign s_axi.S_AXI_RVALID  = r_valid_q;
    assign s_axi.S_AXI_RRESP   = r_resp_q;
    assign s_axi.S_AXI_RDATA   = r_data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else begin
            // Address and data are only taken together, and never while a response is pending.
            aw_ready_q <= s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !b_valid_q && !aw_ready_q;
            if (wr_fire) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi.S_AXI_BREADY) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // NOTE: the register arrays are reset explicitly because core_din must read 0 out of reset.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < IN_REGS; i++) in_regs[i] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < IN_REGS; i++)
                for (int b = 0; b < STRB_W; b++)
                    if (w_idx == 32'(IN_BASE + i) && s_axi.S_AXI_WSTRB[b])
                        in_regs[i][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < OUT_REGS; i++) out_regs[i] <= '0;
        end else if (core_done && busy) begin
            for (int i = 0; i < OUT_REGS; i++) out_regs[i] <= core_dout[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            irq_en     <= 1'b0;
            core_start <= 1'b0;
            irq        <= 1'b0;
        end else begin
            core_start <= start_req;
            irq        <= done && irq_en;
            if (wr_ctrl) irq_en <= s_axi.S_AXI_WDATA[1];
            if (start_req) begin
                busy <= 1'b1;
                done <= 1'b0;
            end
            if (clear_done) done <= 1'b0;
            // Placed last so a completion beats a same-cycle W1C of DONE.
            if (core_done && busy) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        core_din = '0;
        for (int i = 0; i < IN_REGS; i++) core_din[i*DATA_W +: DATA_W] = in_regs[i];
    end

    always_comb begin
        rd_mux = '0;
        if (r_idx == 32'd0) rd_mux[1] = irq_en;
        if (r_idx == 32'd1) rd_mux[1:0] = {done, busy};
        for (int i = 0; i < IN_REGS; i++)
            if (r_idx == 32'(IN_BASE + i)) rd_mux = in_regs[i];
        for (int i = 0; i < OUT_REGS; i++)
            if (r_idx == 32'(OUT_BASE + i)) rd_mux = out_regs[i];
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_resp_q   <= RESP_OKAY;
            r_data_q   <= '0;
        end else begin
            ar_ready_q <= s_axi.S_AXI_ARVALID && !r_valid_q && !ar_ready_q;
            if (rd_fire) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_mux;
                r_resp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axi.S_AXI_RREADY) begin
                r_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axil_regif_core.sv
// Directed and randomized checks of axil_regif_core against a register-map model.
`timescale 1ns/1ps
module tb_axil_regif_core;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 6;
    localparam int IN_REGS  = 3;
    localparam int OUT_REGS = 3;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    logic core_start, core_done, irq;
    logic [IN_REGS*DATA_W-1:0]  core_din;
    logic [OUT_REGS*DATA_W-1:0] core_dout;

    axil_regif_core_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axil_regif_core #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(bus),
        .core_start(core_start), .core_din(core_din), .core_dout(core_dout),
        .core_done(core_done), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    always @(negedge ACLK) if (core_start === 1'b1) start_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Behavioural model of the register map.
    logic [31:0] m_in  [IN_REGS];
    logic [31:0] m_out [OUT_REGS];
    bit m_busy, m_done, m_irq_en;
    int m_starts = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < IN_REGS; i++) m_in[i] = '0;
        for (int i = 0; i < OUT_REGS; i++) m_out[i] = '0;
        m_busy = 0; m_done = 0; m_irq_en = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [ADDR_W-1:0] addr);
        int idx = int'(addr >> 2);
        if (idx == 0) return {30'b0, m_irq_en, 1'b0};
        if (idx == 1) return {30'b0, m_done, m_busy};
        if (idx < 2 + IN_REGS) return m_in[idx-2];
        if (idx < NUM_REGS) return m_out[idx-2-IN_REGS];
        return 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [ADDR_W-1:0] addr);
        return (int'(addr >> 2) >= NUM_REGS) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [95:0] model_din();
        return {m_in[2], m_in[1], m_in[0]};
    endfunction

    function automatic void model_done(input bit was_busy, input logic [95:0] dout);
        if (was_busy) begin
            for (int i = 0; i < OUT_REGS; i++) m_out[i] = dout[32*i +: 32];
            m_busy = 0;
            m_done = 1;
        end
    endfunction

    function automatic void model_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb, input bit done_pulse,
                                        input logic [95:0] dout);
        int idx = int'(addr >> 2);
        bit was_busy = m_busy;
        if (idx == 0 && strb[0]) begin
            m_irq_en = data[1];
            if (data[0] && !m_busy) begin
                m_busy = 1; m_done = 0; m_starts++;
            end
        end else if (idx == 1 && strb[0] && data[1]) begin
            m_done = 0;
        end else if (idx >= 2 && idx < 2 + IN_REGS) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_in[idx-2][8*b +: 8] = data[8*b +: 8];
        end
        if (done_pulse) model_done(was_busy, dout);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge ACLK); #1; end
    endtask

    task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit done_pulse,
                             input logic [95:0] dout, input int b_stall);
        int n = 0;
        logic [1:0] exp_resp = model_resp(addr);
        bus.S_AXI_AWADDR = addr; bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
        while (bus.S_AXI_AWREADY !== 1'b1 && n < 20) begin tick(1); n++; end
        check($sformatf("awready@%0h", addr), bus.S_AXI_AWREADY, 1);
        check($sformatf("wready@%0h", addr), bus.S_AXI_WREADY, 1);
        if (done_pulse) begin core_dout = dout; core_done = 1'b1; end
        tick(1);
        core_done = 1'b0;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        model_write(addr, data, strb, done_pulse, dout);
        check($sformatf("bvalid@%0h", addr), bus.S_AXI_BVALID, 1);
        check($sformatf("bresp@%0h", addr), bus.S_AXI_BRESP, exp_resp);
        for (int i = 0; i < b_stall; i++) begin
            bus.S_AXI_AWADDR = 6'h3C; bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
            tick(1);
            check("bvalid_hold", bus.S_AXI_BVALID, 1);
            check("bresp_hold", bus.S_AXI_BRESP, exp_resp);
            check("no_awready_while_bvalid", bus.S_AXI_AWREADY, 0);
        end
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
        tick(1);
        bus.S_AXI_BREADY = 1'b0;
        check("bvalid_clear", bus.S_AXI_BVALID, 0);
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] addr, input int r_stall,
                            output logic [31:0] data);
        int n = 0;
        logic [31:0] exp_data = model_read(addr);
        logic [1:0]  exp_resp = model_resp(addr);
        bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
        while (bus.S_AXI_ARREADY !== 1'b1 && n < 20) begin tick(1); n++; end
        check($sformatf("arready@%0h", addr), bus.S_AXI_ARREADY, 1);
        tick(1);
        bus.S_AXI_ARVALID = 1'b0;
        check($sformatf("rvalid@%0h", addr), bus.S_AXI_RVALID, 1);
        check($sformatf("rdata@%0h", addr), bus.S_AXI_RDATA, exp_data);
        check($sformatf("rresp@%0h", addr), bus.S_AXI_RRESP, exp_resp);
        data = bus.S_AXI_RDATA;
        for (int i = 0; i < r_stall; i++) begin
            bus.S_AXI_ARADDR = 6'h08; bus.S_AXI_ARVALID = 1'b1;
            tick(1);
            check("rvalid_hold", bus.S_AXI_RVALID, 1);
            check("rdata_hold", bus.S_AXI_RDATA, exp_data);
            check("no_arready_while_rvalid", bus.S_AXI_ARREADY, 0);
        end
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
        tick(1);
        bus.S_AXI_RREADY = 1'b0;
        check("rvalid_clear", bus.S_AXI_RVALID, 0);
    endtask

    task automatic pulse_done(input logic [95:0] dout);
        bit was_busy = m_busy;
        core_dout = dout; core_done = 1'b1;
        tick(1);
        core_done = 1'b0;
        model_done(was_busy, dout);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, bus.S_AXI_AWREADY, 0);
        check({tag, "_wready"}, bus.S_AXI_WREADY, 0);
        check({tag, "_bvalid"}, bus.S_AXI_BVALID, 0);
        check({tag, "_bresp"}, bus.S_AXI_BRESP, 0);
        check({tag, "_arready"}, bus.S_AXI_ARREADY, 0);
        check({tag, "_rvalid"}, bus.S_AXI_RVALID, 0);
        check({tag, "_rresp"}, bus.S_AXI_RRESP, 0);
        check({tag, "_rdata"}, bus.S_AXI_RDATA, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_irq"}, irq, 0);
        check({tag, "_core_din"}, core_din, 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [5:0]  a;
        int          s0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
        bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;  bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        core_done = 1'b0; core_dout = '0;
        model_reset();

        // Reset state
        tick(3);
        ARESET = 1'b0;
        tick(1);
        check_all_zero("reset");
        for (int i = 0; i < NUM_REGS; i++) axi_read(6'(i * 4), 0, rd);

        // Input registers, readback and core_din ordering
        axi_write(6'h08, 32'h1, 4'hF, 0, '0, 0);
        axi_write(6'h0C, 32'h2, 4'hF, 0, '0, 0);
        axi_write(6'h10, 32'h3, 4'hF, 0, '0, 0);
        axi_read(6'h08, 0, rd); axi_read(6'h0C, 0, rd); axi_read(6'h10, 0, rd);
        check("core_din_order", core_din, 96'h00000003_00000002_00000001);

        // Byte strobes
        axi_write(6'h08, 32'h11223344, 4'hF, 0, '0, 0);
        axi_write(6'h08, 32'hAABBCCDD, 4'b0101, 0, '0, 0);
        axi_read(6'h08, 0, rd);
        check("wstrb_merge", rd, 32'h11BB33DD);

        // Start, completion, result capture, irq and W1C
        s0 = start_cnt;
        axi_write(6'h00, 32'h3, 4'hF, 0, '0, 0);
        check("start_one_pulse", start_cnt - s0, 1);
        axi_read(6'h04, 0, rd);
        check("status_busy", rd, 32'h1);
        pulse_done({32'h0C, 32'h0B, 32'h0A});
        check("irq_not_yet", irq, 0);
        tick(1);
        check("irq_set", irq, 1);
        axi_read(6'h14, 0, rd); axi_read(6'h18, 0, rd); axi_read(6'h1C, 0, rd);
        check("result0", rd, 32'h0C);
        axi_read(6'h04, 0, rd);
        check("status_done", rd, 32'h2);
        axi_write(6'h04, 32'h2, 4'hF, 0, '0, 0);
        tick(1);
        check("irq_cleared", irq, 0);

        // Start while busy is ignored; IRQ_EN still updates; set beats W1C
        axi_write(6'h00, 32'h3, 4'hF, 0, '0, 0);
        s0 = start_cnt;
        axi_write(6'h00, 32'h1, 4'hF, 0, '0, 0);
        check("no_start_while_busy", start_cnt - s0, 0);
        axi_read(6'h00, 0, rd);
        check("irq_en_updated", rd, 32'h0);
        axi_write(6'h04, 32'h2, 4'hF, 1, {32'h33, 32'h22, 32'h11}, 0);
        axi_read(6'h04, 0, rd);
        check("done_set_wins", rd, 32'h2);

        // Out-of-range and read-only accesses
        axi_read(6'h20, 0, rd);
        axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, 0, '0, 0);
        axi_write(6'h14, 32'hFFFFFFFF, 4'hF, 0, '0, 0);
        for (int i = 0; i < NUM_REGS; i++) axi_read(6'(i * 4), 0, rd);

        // Concurrent write and read to the same register returns the old value
        fork
            axi_write(6'h0C, 32'hCAFEF00D, 4'hF, 0, '0, 0);
            axi_read(6'h0C, 0, rd);
        join
        check("concurrent_old_value", rd, 32'h2);

        // Back-pressure on both response channels
        axi_write(6'h10, 32'h5A5A5A5A, 4'hF, 0, '0, 5);
        axi_read(6'h10, 5, rd);

        // Randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            a = {4'($urandom_range(0, 15)), 2'($urandom)};
            case ($urandom_range(0, 3))
                0, 1: axi_write(a, $urandom, 4'($urandom), ($urandom_range(0, 5) == 0),
                                {$urandom, $urandom, $urandom}, 0);
                2: axi_read(a, 0, rd);
                default: pulse_done({$urandom, $urandom, $urandom});
            endcase
            tick(1);
            check("rand_core_din", core_din, model_din());
            check("rand_starts", start_cnt, m_starts);
            check("rand_irq", irq, m_done && m_irq_en);
        end

        // Asynchronous reset in the middle of a transaction
        axi_write(6'h00, 32'h3, 4'hF, 0, '0, 0);
        pulse_done({$urandom, $urandom, $urandom});
        tick(1);
        check("pre_reset_irq", irq, 1);
        bus.S_AXI_AWADDR = 6'h08; bus.S_AXI_WDATA = 32'h1234; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 6'h04; bus.S_AXI_ARVALID = 1'b1;
        tick(1);
        check("pre_reset_awready", bus.S_AXI_AWREADY, 1);
        ARESET = 1'b1;
        #1;
        check_all_zero("async_reset");
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        tick(2);
        ARESET = 1'b0;
        model_reset();
        tick(1);
        axi_read(6'h08, 0, rd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
